// File: rtl/stream_pkg.sv
// Shared stream package: FSM state encoding and default element geometry.
// Used by the serializer and the element FIFO instances that sit behind it.
package stream_pkg;

  localparam int unsigned ELE_BANDWIDTH_DEF = 8;
  localparam int unsigned NUM_ELE_DEF       = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/stream_serializer_counter.sv
// mod_counter: up-counter that saturates at MAX_CNT.
//  i_clk   clock
//  i_rst_n synchronous active-low reset (count -> 0)
//  i_clr   synchronous clear (count -> 0)
//  i_en    count enable
//  o_cnt   current count
//  o_tc    terminal count flag (o_cnt == MAX_CNT)
module mod_counter #(
  parameter int unsigned CNT_BANDWIDTH = 2,
  parameter int unsigned MAX_CNT       = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  output logic [CNT_BANDWIDTH-1:0] o_cnt,
  output logic                     o_tc
);

  assign o_tc = (o_cnt == CNT_BANDWIDTH'(MAX_CNT));

  // Never counts past MAX_CNT; wrapping only happens through i_clr.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      o_cnt <= '0;
    end else if (i_en && !o_tc) begin
      o_cnt <= o_cnt + CNT_BANDWIDTH'(1);
    end
  end

endmodule

// File: rtl/stream_serializer.sv
// stream_serializer: takes one NUM_ELE-element word per handshake and emits
// its elements LSB-first, one per downstream handshake, at 1 element/cycle
// including across word boundaries.
//  i_clk    clock
//  i_rst_n  synchronous active-low reset
//  i_word   input word, element k = i_word[k*ELE_BANDWIDTH +: ELE_BANDWIDTH]
//  i_valid  input word valid
//  o_ready  word can be accepted this cycle (combinational on i_ready)
//  o_valid  o_data holds a valid element
//  o_data   current element
//  i_ready  downstream accepts o_data
//  o_last   (SER_LAST_EN only) current element is the last of its word
// Optional feature macro: SER_LAST_EN.
module stream_serializer
  import stream_pkg::*;
#(
  parameter int unsigned ELE_BANDWIDTH = ELE_BANDWIDTH_DEF,
  parameter int unsigned NUM_ELE       = NUM_ELE_DEF
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_ELE*ELE_BANDWIDTH-1:0] i_word,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic                             o_valid,
  output logic [ELE_BANDWIDTH-1:0]         o_data,
  input  logic                             i_ready
`ifdef SER_LAST_EN
  ,
  output logic                             o_last
`endif
);

  localparam int unsigned CNT_BANDWIDTH  = (NUM_ELE < 2) ? 1 : $clog2(NUM_ELE);
  localparam int unsigned WORD_BANDWIDTH = NUM_ELE * ELE_BANDWIDTH;

  if (NUM_ELE < 2) begin : g_bad_num_ele
    $error("stream_serializer: NUM_ELE must be >= 2");
  end

  state_t                    state;
  logic [WORD_BANDWIDTH-1:0] word_q;
  logic [CNT_BANDWIDTH-1:0]  idx;
  logic                      idx_tc;
  logic                      word_acc;
  logic                      send_adv;

  assign o_ready  = (state == ST_IDLE) | ((state == ST_SEND) & idx_tc & i_ready);
  assign word_acc = i_valid & o_ready;
  // Advance within the word; the last element is retired by a reload or IDLE.
  assign send_adv = (state == ST_SEND) & i_ready & ~idx_tc;

  mod_counter #(
    .CNT_BANDWIDTH(CNT_BANDWIDTH),
    .MAX_CNT      (NUM_ELE - 1)
  ) u_idx (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (word_acc),
    .i_en   (send_adv),
    .o_cnt  (idx),
    .o_tc   (idx_tc)
  );

  // Word FSM; a load on the last element keeps SEND so no bubble appears.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      word_q <= '0;
    end else if (word_acc) begin
      state  <= ST_SEND;
      word_q <= i_word;
    end else if ((state == ST_SEND) && i_ready && idx_tc) begin
      state  <= ST_IDLE;
    end
  end

  assign o_valid = (state == ST_SEND);

  // Element mux driven only by registered state.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < int'(NUM_ELE); k++) begin
      if (idx == CNT_BANDWIDTH'(k)) begin
        o_data = word_q[k*ELE_BANDWIDTH +: ELE_BANDWIDTH];
      end
    end
  end

`ifdef SER_LAST_EN
  assign o_last = (state == ST_SEND) & idx_tc;
`endif

endmodule
